// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_gen
// Description : LED pattern generator with POINT, BAR, CHASE and BOUNCE modes
//               stepped by a programmable animation tick divider.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
    parameter int LED_COUNT = 16,
    parameter int IDX_WIDTH = 4,
    parameter int TICK_DIV  = 25_000_000
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic                 i_Load,
    input  logic [1:0]           i_Mode,
    input  logic [IDX_WIDTH-1:0] i_LED_Value,
    output logic [LED_COUNT-1:0] o_LED,
    output logic                 o_Tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CNT_W-1:0]     C_CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]     C_CNT_ONE    = CNT_W'(1);
    localparam logic [IDX_WIDTH-1:0] C_POS_LAST   = IDX_WIDTH'(LED_COUNT - 1);
    localparam logic [IDX_WIDTH-1:0] C_POS_PENULT = IDX_WIDTH'(LED_COUNT - 2);
    localparam logic [IDX_WIDTH-1:0] C_POS_ONE    = IDX_WIDTH'(1);

    typedef enum logic [1:0] {
        MODE_POINT  = 2'd0,
        MODE_BAR    = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    mode_t                mode_q, mode_d;
    logic [IDX_WIDTH-1:0] pos_q,  pos_d;
    logic                 dir_q,  dir_d;
    logic [CNT_W-1:0]     cnt_q,  cnt_d;
    logic [LED_COUNT-1:0] led_q,  led_d;
    logic                 tick_q, tick_d;

    logic                 w_wrap;
    logic [LED_COUNT-1:0] w_onehot;
    logic [LED_COUNT-1:0] w_bar;

    // Per-LED decode of the current position into one-hot and bar patterns.
    genvar n;
    generate
        for (n = 0; n < LED_COUNT; n++) begin : g_led
            assign w_onehot[n] = (pos_q == IDX_WIDTH'(n));
            assign w_bar[n]    = (pos_q >= IDX_WIDTH'(n));
        end
    endgenerate

    assign w_wrap = (cnt_q == C_CNT_LAST);

    always_comb begin
        mode_d = mode_q;
        pos_d  = pos_q;
        dir_d  = dir_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;

        if (i_Load) begin
            mode_d = mode_t'(i_Mode);
            pos_d  = (i_LED_Value > C_POS_LAST) ? C_POS_LAST : i_LED_Value;
            dir_d  = 1'b1;
            cnt_d  = '0;
        end else begin
            tick_d = w_wrap;
            cnt_d  = w_wrap ? '0 : (cnt_q + C_CNT_ONE);
            if (w_wrap) begin
                case (mode_q)
                    MODE_POINT: ;
                    MODE_BAR:   ;
                    MODE_CHASE: begin
                        pos_d = (pos_q == C_POS_LAST) ? '0 : (pos_q + C_POS_ONE);
                    end
                    MODE_BOUNCE: begin
                        // Turnaround happens on the end LED itself, so each end is lit for one step.
                        if (dir_q) begin
                            if (pos_q == C_POS_LAST) begin
                                dir_d = 1'b0;
                                pos_d = C_POS_PENULT;
                            end else begin
                                pos_d = pos_q + C_POS_ONE;
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = 1'b1;
                                pos_d = C_POS_ONE;
                            end else begin
                                pos_d = pos_q - C_POS_ONE;
                            end
                        end
                    end
                endcase
            end
        end

        case (mode_q)
            MODE_POINT:  led_d = w_onehot;
            MODE_BAR:    led_d = w_bar;
            MODE_CHASE:  led_d = w_onehot;
            MODE_BOUNCE: led_d = w_onehot;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            mode_q <= MODE_POINT;
            pos_q  <= '0;
            dir_q  <= 1'b1;
            cnt_q  <= '0;
            led_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            tick_q <= tick_d;
        end
    end

    assign o_LED  = led_q;
    assign o_Tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pattern_gen
// Description : Self-checking bench for led_pattern_gen (16 LEDs / div 4, and
//               10 LEDs / div 1), directed steps plus randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;

    logic        clk;
    logic        rst_a, ld_a, rst_b, ld_b;
    logic [1:0]  mode_a, mode_b;
    logic [3:0]  val_a, val_b;
    logic [15:0] o_led_a;
    logic [9:0]  o_led_b;
    logic        o_tick_a, o_tick_b;

    int total = 0;
    int bad   = 0;

    // Reference model: animation position derived from steps elapsed since load.
    int          m_n[2]  = '{16, 10};
    int          m_td[2] = '{4, 1};
    int          m_mode[2];
    int          m_base[2];
    int          m_age[2];
    logic [15:0] e_led[2];
    logic        e_tick[2];

    led_pattern_gen #(.LED_COUNT(16), .IDX_WIDTH(4), .TICK_DIV(4)) u_dut_a (
        .i_Clk(clk), .i_Reset(rst_a), .i_Load(ld_a), .i_Mode(mode_a),
        .i_LED_Value(val_a), .o_LED(o_led_a), .o_Tick(o_tick_a)
    );

    led_pattern_gen #(.LED_COUNT(10), .IDX_WIDTH(4), .TICK_DIV(1)) u_dut_b (
        .i_Clk(clk), .i_Reset(rst_b), .i_Load(ld_b), .i_Mode(mode_b),
        .i_LED_Value(val_b), .o_LED(o_led_b), .o_Tick(o_tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pattern(int n, int td, int mode, int base, int age);
        int steps, ph, v;
        steps = age / td;
        v = 0;
        case (mode)
            0: v = 1 << base;
            1: v = (1 << (base + 1)) - 1;
            2: v = 1 << ((base + steps) % n);
            default: begin
                ph = (base + steps) % (2 * n - 2);
                v  = 1 << ((ph < n) ? ph : (2 * n - 2 - ph));
            end
        endcase
        return v[15:0];
    endfunction

    task automatic model_edge(int i, logic rst, logic ld, logic [1:0] md, logic [3:0] val);
        if (rst) begin
            e_led[i]  = '0;
            e_tick[i] = 1'b0;
            m_mode[i] = 0;
            m_base[i] = 0;
            m_age[i]  = 0;
        end else begin
            e_led[i] = pattern(m_n[i], m_td[i], m_mode[i], m_base[i], m_age[i]);
            if (ld) begin
                m_mode[i] = int'(md);
                m_base[i] = (int'(val) > m_n[i] - 1) ? m_n[i] - 1 : int'(val);
                m_age[i]  = 0;
                e_tick[i] = 1'b0;
            end else begin
                m_age[i]  = m_age[i] + 1;
                e_tick[i] = ((m_age[i] % m_td[i]) == 0);
            end
        end
    endtask

    task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge(0, rst_a, ld_a, mode_a, val_a);
        model_edge(1, rst_b, ld_b, mode_b, val_b);
        #1;
        chk("led_a", o_led_a, e_led[0]);
        chk("tick_a", {15'd0, o_tick_a}, {15'd0, e_tick[0]});
        chk("led_b", {6'd0, o_led_b}, e_led[1]);
        chk("tick_b", {15'd0, o_tick_b}, {15'd0, e_tick[1]});
        // Idle inputs wander so that unloaded mode/value changes are exercised.
        if (!ld_a) begin mode_a = 2'($urandom); val_a = 4'($urandom); end
        if (!ld_b) begin mode_b = 2'($urandom); val_b = 4'($urandom); end
    endtask

    task automatic load_a(logic [1:0] md, logic [3:0] val);
        ld_a = 1'b1; mode_a = md; val_a = val;
        cyc();
        ld_a = 1'b0;
    endtask

    task automatic load_b(logic [1:0] md, logic [3:0] val);
        ld_b = 1'b1; mode_b = md; val_b = val;
        cyc();
        ld_b = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; ld_a = 1'b0; mode_a = 2'd0; val_a = 4'd0;
        rst_b = 1'b1; ld_b = 1'b0; mode_b = 2'd0; val_b = 4'd0;

        // Reset held two cycles, then first edge after release lights LED 0.
        cyc();
        cyc();
        chk("rst_led", o_led_a, 16'h0000);
        chk("rst_tick", {15'd0, o_tick_a}, 16'h0000);
        rst_a = 1'b0; rst_b = 1'b0;
        cyc();
        chk("rel_led", o_led_a, 16'h0001);
        chk("rel_led_b", {6'd0, o_led_b}, 16'h0001);

        // POINT and BAR
        load_a(2'd0, 4'd5);  cyc(); chk("point5", o_led_a, 16'h0020);
        load_a(2'd1, 4'd3);  cyc(); chk("bar3",   o_led_a, 16'h000F);
        load_a(2'd1, 4'd15); cyc(); chk("bar15",  o_led_a, 16'hFFFF);
        load_a(2'd1, 4'd0);  cyc(); chk("bar0",   o_led_a, 16'h0001);

        // CHASE wrap from 14
        load_a(2'd2, 4'd14);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (i == 1) chk("chase14", o_led_a, 16'h4000);
            if (i == 5) chk("chase15", o_led_a, 16'h8000);
            if (i == 9) chk("chase0",  o_led_a, 16'h0001);
            if (i == 4 || i == 8) chk("chase_tick", {15'd0, o_tick_a}, 16'h0001);
        end

        // BOUNCE turnaround at the top
        load_a(2'd3, 4'd14);
        for (int i = 1; i <= 13; i++) begin
            cyc();
            if (i == 1)  chk("bnc_a0", o_led_a, 16'h4000);
            if (i == 5)  chk("bnc_a1", o_led_a, 16'h8000);
            if (i == 9)  chk("bnc_a2", o_led_a, 16'h4000);
            if (i == 13) chk("bnc_a3", o_led_a, 16'h2000);
        end

        // BOUNCE full sweep from 1
        load_a(2'd3, 4'd1);
        for (int i = 1; i <= 125; i++) begin
            cyc();
            if (i == 1)   chk("bnc_b0", o_led_a, 16'h0002);
            if (i == 5)   chk("bnc_b1", o_led_a, 16'h0004);
            if (i == 57)  chk("bnc_top", o_led_a, 16'h8000);
            if (i == 117) chk("bnc_bot", o_led_a, 16'h0001);
            if (i == 121) chk("bnc_up",  o_led_a, 16'h0002);
        end

        // Load colliding with a counter wrap
        load_a(2'd2, 4'd0);
        cyc(); cyc(); cyc();
        load_a(2'd0, 4'd7);
        chk("coll_notick", {15'd0, o_tick_a}, 16'h0000);
        cyc();
        chk("coll_led", o_led_a, 16'h0080);
        chk("coll_notick2", {15'd0, o_tick_a}, 16'h0000);
        cyc(); cyc(); cyc();
        chk("coll_tick", {15'd0, o_tick_a}, 16'h0001);

        // Reset during CHASE
        load_a(2'd2, 4'd3);
        for (int i = 0; i < 6; i++) cyc();
        rst_a = 1'b1;
        cyc();
        chk("rst_chase_led", o_led_a, 16'h0000);
        chk("rst_chase_tick", {15'd0, o_tick_a}, 16'h0000);
        rst_a = 1'b0;
        cyc();
        chk("rst_chase_rel", o_led_a, 16'h0001);

        // Clamp and divide-by-one on the 10-LED instance
        load_b(2'd0, 4'd12);
        cyc();
        chk("clamp12", {6'd0, o_led_b}, 16'h0200);
        load_b(2'd2, 4'd7);
        for (int i = 1; i <= 6; i++) begin
            cyc();
            chk("div1_tick", {15'd0, o_tick_b}, 16'h0001);
        end
        chk("div1_led", {6'd0, o_led_b}, 16'h0004);

        // Randomized traffic on both instances
        for (int i = 0; i < 400; i++) begin
            rst_a = ($urandom_range(0, 59) == 0);
            rst_b = ($urandom_range(0, 59) == 0);
            ld_a  = ($urandom_range(0, 7) == 0);
            ld_b  = ($urandom_range(0, 7) == 0);
            cyc();
        end
        rst_a = 1'b0; rst_b = 1'b0; ld_a = 1'b0; ld_b = 1'b0;
        for (int i = 0; i < 20; i++) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
